// File: rtl/alu_pkg.sv
// Shared opcode encodings and controller state type for the sequenced ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DIV  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring on magnitudes),
// one bit per clock, sharing the accumulator, shift register and iteration counter.
module alu_muldiv_core
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         go,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         fin
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_DONE = CW'(W);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [W:0]   acc_q, acc_d;
  logic [W-1:0]        qr_q, qr_d;
  logic [W-1:0]        m_q, m_d;
  logic                qm1_q, qm1_d;
  logic                div_q, div_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;

  logic signed [W:0]   m_sx;
  logic signed [W:0]   booth_sum;
  logic [W:0]          div_rsh;
  logic [W:0]          div_diff;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  // Booth pair {Q0, Q-1}: 10 subtracts the multiplicand, 01 adds it.
  assign m_sx      = $signed({m_q[W-1], m_q});
  assign booth_sum = (qr_q[0] && !qm1_q) ? acc_q - m_sx :
                     (!qr_q[0] && qm1_q) ? acc_q + m_sx : acc_q;
  assign div_rsh   = {acc_q[W-1:0], qr_q[W-1]};
  assign div_diff  = div_rsh - {1'b0, m_q};

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    qr_d      = qr_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (go) begin
      cnt_d     = '0;
      acc_d     = '0;
      qm1_d     = 1'b0;
      div_d     = is_div;
      neg_quo_d = a[W-1] ^ b[W-1];
      neg_rem_d = a[W-1];
      qr_d      = is_div ? mag(a) : a;
      m_d       = is_div ? mag(b) : b;
    end else if (cnt_q != CNT_DONE) begin
      cnt_d = cnt_q + CW'(1);
      if (div_q) begin
        if (!div_diff[W]) begin
          acc_d = div_diff;
          qr_d  = {qr_q[W-2:0], 1'b1};
        end else begin
          acc_d = div_rsh;
          qr_d  = {qr_q[W-2:0], 1'b0};
        end
      end else begin
        acc_d = {booth_sum[W], booth_sum[W:1]};
        qr_d  = {booth_sum[0], qr_q[W-1:1]};
        qm1_d = qr_q[0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      cnt_q <= CNT_DONE;
    end else begin
      cnt_q <= cnt_d;
    end
    acc_q     <= acc_d;
    qr_q      <= qr_d;
    m_q       <= m_d;
    qm1_q     <= qm1_d;
    div_q     <= div_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
  end

  // Divide works on magnitudes; signs are restored here (remainder follows the dividend).
  assign fin = (cnt_q == CNT_DONE);
  assign lo  = (div_q && neg_quo_q) ? -qr_q : qr_q;
  assign hi  = (div_q && neg_rem_q) ? -acc_q[W-1:0] : acc_q[W-1:0];

endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle logic/arithmetic/shift ops plus multi-cycle signed MUL/DIV
// behind a start/busy/done handshake; Z is a 2W-bit registered result.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int W   = 32,
  localparam int SHW = $clog2(W)
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           start,
  input  logic           IncPC,
  input  logic [4:0]     opcode,
  input  logic [W-1:0]   Y,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] Z,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero
);

  state_e         state_q, state_d;
  logic [2*W-1:0] z_q, z_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   b_q, b_d;
  logic [4:0]     op_q, op_d;
  logic           inc_q, inc_d;

  logic           accept;
  logic           core_go;
  logic           core_is_div;
  logic [W-1:0]   core_hi;
  logic [W-1:0]   core_lo;
  logic           core_fin;

  function automatic logic [2*W-1:0] exec_op(input logic [4:0] op, input logic inc,
                                             input logic [W-1:0] y, input logic [W-1:0] b);
    logic signed [W-1:0] ys;
    logic [SHW-1:0]      amt;
    logic [2*W-1:0]      rot;
    logic [W-1:0]        res;
    ys  = y;
    amt = b[SHW-1:0];
    rot = '0;
    res = '0;
    if (inc) return {{W{1'b0}}, b + W'(1)};
    case (op)
      OP_AND:  res = y & b;
      OP_OR:   res = y | b;
      OP_NOT:  res = ~y;
      OP_NEG:  res = -y;
      OP_ADD:  res = y + b;
      OP_SUB:  res = y - b;
      OP_SHR:  res = y >> amt;
      OP_SHRA: res = ys >>> amt;
      OP_SHL:  res = y << amt;
      OP_ROR: begin
        rot = {y, y} >> amt;
        res = rot[W-1:0];
      end
      OP_ROL: begin
        rot = {y, y} << amt;
        res = rot[2*W-1:W];
      end
      // Only reaches EXEC with a zero divisor.
      OP_DIV:  return {y, {W{1'b1}}};
      default: res = '0;
    endcase
    return {{W{1'b0}}, res};
  endfunction

  assign accept      = start && (state_q == ST_IDLE) && !busy_q;
  assign core_is_div = (opcode == OP_DIV);
  assign core_go     = accept && !IncPC &&
                       ((opcode == OP_MUL) || (core_is_div && (B != '0)));

  alu_muldiv_core #(.W(W)) u_core (
    .clock  (clock),
    .clear  (clear),
    .go     (core_go),
    .is_div (core_is_div),
    .a      (Y),
    .b      (B),
    .hi     (core_hi),
    .lo     (core_lo),
    .fin    (core_fin)
  );

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    y_d     = y_q;
    b_d     = b_q;
    op_d    = op_q;
    inc_d   = inc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          y_d   = Y;
          b_d   = B;
          op_d  = opcode;
          inc_d = IncPC;
          dbz_d = 1'b0;
          if (core_go) state_d = core_is_div ? ST_DIV : ST_MUL;
          else         state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        z_d     = exec_op(op_q, inc_q, y_q, b_q);
        done_d  = 1'b1;
        dbz_d   = !inc_q && (op_q == OP_DIV);
        state_d = ST_IDLE;
      end
      ST_MUL, ST_DIV: begin
        if (core_fin) begin
          z_d     = {core_hi, core_lo};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
    y_q   <= y_d;
    b_q   <= b_d;
    op_q  <= op_d;
    inc_q <= inc_d;
  end

  assign Z           = z_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
